// File: rtl/req_ack_initiator.sv
// req_ack_initiator: FIFO-buffered initiator for a four-phase req/ack
// handshake toward slow-sampling agents.
// Ports:
//   clk, rstn            clock, async active-low reset
//   in_valid/in_data     command input (transfer when in_valid & in_ready)
//   in_ready             FIFO has room
//   req, req_data        registered request level and payload
//   ack                  agent acknowledge level (clk-synchronous)
//   done_pulse           one cycle per completed handshake
//   timeout_pulse        one cycle per aborted handshake
//   level                FIFO occupancy
// Optional macro REQ_ACK_TIMEOUT_EN adds a per-phase timeout counter.
module req_ack_initiator #(
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        in_data,
    output logic                     in_ready,
    output logic                     req,
    output logic [DATA_W-1:0]        req_data,
    input  logic                     ack,
    output logic                     done_pulse,
    output logic                     timeout_pulse,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        REQ_HI,
        REQ_LO
    } state_t;

    state_t            state;
    state_t            state_n;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wptr;
    logic [AW:0]       rptr;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              tmo;
    logic              req_n;
    logic [DATA_W-1:0] req_data_n;
    logic              done_n;
    logic              to_n;

    // Extra pointer MSB distinguishes full from empty.
    assign full     = (wptr[AW] != rptr[AW]) &&
                      (wptr[AW-1:0] == rptr[AW-1:0]);
    assign empty    = (wptr == rptr);
    assign level    = wptr - rptr;
    assign in_ready = ~full;
    assign push     = in_valid & ~full;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr[AW-1:0]] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
        end
    end

`ifdef REQ_ACK_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    logic [CW-1:0] cnt;

    assign tmo = (cnt == CW'(TIMEOUT_CYC - 1));

    // Phase timer: restarts on every state change, runs while busy.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (state_n != state) begin
            cnt <= '0;
        end else if (state != IDLE) begin
            cnt <= cnt + 1'b1;
        end
    end
`else
    assign tmo = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= IDLE;
            req           <= 1'b0;
            req_data      <= '0;
            done_pulse    <= 1'b0;
            timeout_pulse <= 1'b0;
        end else begin
            state         <= state_n;
            req           <= req_n;
            req_data      <= req_data_n;
            done_pulse    <= done_n;
            timeout_pulse <= to_n;
        end
    end

    always_comb begin
        state_n    = state;
        req_n      = req;
        req_data_n = req_data;
        done_n     = 1'b0;
        to_n       = 1'b0;
        pop        = 1'b0;
        unique case (state)
            IDLE: begin
                // A lingering ack from the last handshake blocks launch.
                if (!empty && !ack) begin
                    state_n    = REQ_HI;
                    pop        = 1'b1;
                    req_n      = 1'b1;
                    req_data_n = mem[rptr[AW-1:0]];
                end
            end
            REQ_HI: begin
                if (ack) begin
                    state_n = REQ_LO;
                    req_n   = 1'b0;
                end else if (tmo) begin
                    state_n = IDLE;
                    req_n   = 1'b0;
                    to_n    = 1'b1;
                end
            end
            REQ_LO: begin
                if (!ack) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end else if (tmo) begin
                    state_n = IDLE;
                    to_n    = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                req_n   = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_req_ack_initiator.sv
// tb_req_ack_initiator: randomized and directed bench for
// req_ack_initiator against a queue-based behavioural model.
module tb_req_ack_initiator;

    localparam int DATA_W      = 32;
    localparam int DEPTH       = 4;
    localparam int TIMEOUT_CYC = 8;
`ifdef REQ_ACK_TIMEOUT_EN
    localparam bit TMO = 1'b1;
`else
    localparam bit TMO = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rstn;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              req;
    logic [DATA_W-1:0] req_data;
    logic              ack;
    logic              done_pulse;
    logic              timeout_pulse;
    logic [2:0]        level;

    req_ack_initiator #(
        .DATA_W      (DATA_W),
        .DEPTH       (DEPTH),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_ready      (in_ready),
        .req           (req),
        .req_data      (req_data),
        .ack           (ack),
        .done_pulse    (done_pulse),
        .timeout_pulse (timeout_pulse),
        .level         (level)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int dn_cnt = 0;
    int to_cnt = 0;

    // Model: pending commands, handshake phase (0 idle, 1 req high,
    // 2 waiting ack low), and expected registered outputs.
    logic [DATA_W-1:0] mq[$];
    int                ph;
    int                m_cnt;
    logic              m_req;
    logic [DATA_W-1:0] m_data;
    logic              m_done;
    logic              m_to;

    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] got_q[$];

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        ph     = 0;
        m_cnt  = 0;
        m_req  = 1'b0;
        m_data = '0;
        m_done = 1'b0;
        m_to   = 1'b0;
    endtask

    task automatic model_edge();
        int sz;
        bit psh;
        bit expire;
        sz     = mq.size();
        psh    = in_valid && (sz < DEPTH);
        expire = TMO && (m_cnt == TIMEOUT_CYC - 1);
        m_done = 1'b0;
        m_to   = 1'b0;
        if (ph == 0) begin
            if (sz > 0 && !ack) begin
                m_data = mq.pop_front();
                m_req  = 1'b1;
                ph     = 1;
                m_cnt  = 0;
            end
        end else if (ph == 1 && ack) begin
            m_req = 1'b0;
            ph    = 2;
            m_cnt = 0;
        end else if (ph == 2 && !ack) begin
            ph     = 0;
            m_done = 1'b1;
        end else if (expire) begin
            m_req = 1'b0;
            m_to  = 1'b1;
            ph    = 0;
            m_cnt = 0;
        end else begin
            m_cnt++;
        end
        if (psh) mq.push_back(in_data);
    endtask

    task automatic compare();
        check("req", req, m_req);
        check("req_data", req_data, m_data);
        check("level", level, mq.size());
        check("in_ready", in_ready, mq.size() < DEPTH);
        check("done_pulse", done_pulse, m_done);
        check("timeout_pulse", timeout_pulse, m_to);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        compare();
        if (done_pulse) begin
            dn_cnt++;
            got_q.push_back(req_data);
        end
        if (timeout_pulse) to_cnt++;
    endtask

    task automatic push_hold(logic [DATA_W-1:0] d);
        bit acc;
        in_valid = 1'b1;
        in_data  = d;
        for (int i = 0; i < 200; i++) begin
            acc = in_ready;
            tick();
            if (acc) begin
                exp_q.push_back(d);
                break;
            end
        end
        if (!acc) check("push_stuck", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic handshake();
        int n;
        n = 0;
        while (!req && n < 50) begin
            tick();
            n++;
        end
        check("hs_req_seen", req, 1);
        repeat ($urandom_range(1, 3)) tick();
        ack = 1'b1;
        tick();
        check("hs_req_drop", req, 0);
        repeat ($urandom_range(0, 1)) tick();
        ack = 1'b0;
        tick();
        check("hs_done", done_pulse, 1);
    endtask

    task automatic check_order(string tag);
        check({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check(tag, got_q[i], exp_q[i]);
        end
        exp_q.delete();
        got_q.delete();
    endtask

    initial begin
        int base;
        rstn     = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        ack      = 1'b0;
        model_reset();
        #2;
        compare();
        @(posedge clk);
        @(posedge clk);
        #1;
        rstn = 1'b1;

        // Single command
        exp_q.delete();
        got_q.delete();
        base = dn_cnt;
        push_hold(32'hA5A5_0001);
        check("single_lvl", level, 1);
        tick();
        check("single_req", req, 1);
        check("single_data", req_data, 32'hA5A5_0001);
        repeat (2) tick();
        ack = 1'b1;
        tick();
        check("single_drop", req, 0);
        tick();
        ack = 1'b0;
        tick();
        tick();
        check("single_done_n", dn_cnt - base, 1);
        check("single_lvl0", level, 0);
        check_order("single_ord");

        // Fill and drain across the pointer wrap
        for (int i = 0; i < 5; i++) push_hold($urandom);
        check("fill_ready", in_ready, 0);
        check("fill_level", level, 4);
        for (int i = 0; i < 5; i++) handshake();
        tick();
        check_order("fill_ord");

        // Stale ack
        ack = 1'b1;
        push_hold(32'h5A1E_0000);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("stale_req", req, 0);
        end
        ack = 1'b0;
        tick();
        check("stale_launch", req, 1);
        handshake();
        tick();
        exp_q.delete();
        got_q.delete();

        // Push on the same edge as a launch
        ack = 1'b1;
        push_hold(32'h0000_0011);
        push_hold(32'h0000_0022);
        check("simul_pre", level, 2);
        ack      = 1'b0;
        in_valid = 1'b1;
        in_data  = 32'h0000_0033;
        exp_q.push_back(in_data);
        tick();
        in_valid = 1'b0;
        check("simul_level", level, 2);
        check("simul_req", req, 1);
        for (int i = 0; i < 3; i++) handshake();
        tick();
        check_order("simul_ord");

        // Unanswered handshake
        base = to_cnt;
        push_hold(32'h7100_0001);
        push_hold(32'h7100_0002);
        repeat (110) tick();
`ifdef REQ_ACK_TIMEOUT_EN
        check("to_pulses", to_cnt - base, 2);
        check("to_req_low", req, 0);
        check("to_level", level, 0);
`else
        check("noto_req", req, 1);
        check("noto_pulses", to_cnt - base, 0);
        handshake();
        handshake();
`endif
        tick();

        // Reset during REQ_HI with two queued
        push_hold($urandom);
        push_hold($urandom);
        push_hold($urandom);
        check("rst_pre_req", req, 1);
        check("rst_pre_lvl", level, 2);
        #3;
        rstn = 1'b0;
        #1;
        model_reset();
        check("rst_req", req, 0);
        check("rst_level", level, 0);
        check("rst_ready", in_ready, 1);
        check("rst_done", done_pulse, 0);
        check("rst_to", timeout_pulse, 0);
        #2;
        rstn = 1'b1;
        repeat (3) tick();

        // Random traffic with a lazy agent
        for (int i = 0; i < 600; i++) begin
            in_valid = ($urandom_range(0, 1) == 1);
            in_data  = $urandom;
            if ($urandom_range(0, 2) == 0) ack = req;
            if ($urandom_range(0, 15) == 0) ack = ~ack;
            tick();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 1) == 0) ack = req;
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
